miter_seq_checker: RTL

- Clocked, multi-channel successor to the single-bit combinational gold/gate miter used in partition equivalence runs.
- Compares NCH channels of WIDTH-bit gold and gate outputs on every valid sample, with a per-bit gold don't-care mask standing in for gold X.
- Keeps a saturating mismatch count, a sticky fail flag, a first-mismatch capture record and a cover-hit flag.
- Used in simulation and FPGA replay of partitions of aes_cipher_top, where combinational assert/cover is not available.

---
 rtl/miter_pkg.sv | 29 ++
 rtl/miter_lane_cmp.sv | 21 ++
 rtl/miter_seq_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/miter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | miter_pkg: shared types and helpers for the sequential gold/gate     |
// | miter checker.                          Revision: 1.0                |
// +----------------------------------------------------------------------+
package miter_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALT   = 2'd2
    } state_e;

    localparam logic [63:0] SAT_ONES = '1;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment that sticks at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input int w);
        logic [63:0] top;
        top = SAT_ONES >> (64 - w);
        return (cnt == top) ? cnt : cnt + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/miter_lane_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | miter_lane_cmp: per-channel masked XOR and OR-reduce.                |
// |                                         Revision: 1.0                |
// +----------------------------------------------------------------------+
module miter_lane_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gold,
    input  logic [WIDTH-1:0] gate,
    input  logic [WIDTH-1:0] dc,
    input  logic             mask,
    output logic [WIDTH-1:0] diff,
    output logic             mism
);

    assign diff = (gold ^ gate) & ~dc & {WIDTH{~mask}};
    assign mism = |diff;

endmodule
`default_nettype wire

// File: rtl/miter_seq_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | miter_seq_checker: clocked multi-channel gold/gate miter with        |
// | counters, sticky fail/cover flags and first-mismatch capture.        |
// |                                         Revision: 1.0                |
// +----------------------------------------------------------------------+
module miter_seq_checker
    import miter_pkg::*;
#(
    parameter  int NCH    = 4,
    parameter  int WIDTH  = 8,
    parameter  int CNT_W  = 16,
    parameter  int WARMUP = 2,
    localparam int CH_W   = ch_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [NCH*WIDTH-1:0] gold,
    input  logic [NCH*WIDTH-1:0] gate,
    input  logic [NCH*WIDTH-1:0] dc,
    input  logic [NCH-1:0]       ch_mask,
    input  logic                 mode,
    output logic                 fail,
    output logic                 cover_hit,
    output logic [CNT_W-1:0]     mism_cnt,
    output logic [CNT_W-1:0]     samp_cnt,
    output logic [CH_W-1:0]      first_ch,
    output logic [WIDTH-1:0]     first_diff,
    output logic [CNT_W-1:0]     first_idx,
    output logic                 busy
);

    localparam int     WC_W      = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam state_e RST_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    logic [NCH*WIDTH-1:0] lane_diff;
    logic [NCH-1:0]       lane_mism;

    logic                 s1_valid;
    logic                 s1_mode;
    logic [NCH*WIDTH-1:0] s1_diff;
    logic [NCH-1:0]       s1_mism;

    state_e               state;
    state_e               state_nxt;
    logic [WC_W-1:0]      wcnt;
    logic [WC_W-1:0]      wcnt_inc;
    logic                 mism_any;
    logic                 counted;
    logic                 capture;
    logic                 cover_set;
    logic [CH_W-1:0]      enc_ch;
    logic [WIDTH-1:0]     enc_diff;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        miter_lane_cmp #(
            .WIDTH (WIDTH)
        ) u_cmp (
            .gold (gold[c*WIDTH +: WIDTH]),
            .gate (gate[c*WIDTH +: WIDTH]),
            .dc   (dc[c*WIDTH +: WIDTH]),
            .mask (ch_mask[c]),
            .diff (lane_diff[c*WIDTH +: WIDTH]),
            .mism (lane_mism[c])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_diff  <= '0;
            s1_mism  <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_diff  <= '0;
            s1_mism  <= '0;
        end else begin
            s1_valid <= in_valid & en;
            if (in_valid & en) begin
                s1_mode <= mode;
                s1_diff <= lane_diff;
                s1_mism <= lane_mism;
            end
        end
    end

    // Lowest mismatching channel wins: scan downward so the last hit is the lowest.
    always_comb begin
        enc_ch   = '0;
        enc_diff = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (s1_mism[c]) begin
                enc_ch   = CH_W'(c);
                enc_diff = s1_diff[c*WIDTH +: WIDTH];
            end
        end
    end

    assign mism_any  = |s1_mism;
    assign wcnt_inc  = wcnt + 1'b1;
    assign counted   = s1_valid && (state != ST_WARMUP);
    assign capture   = s1_valid && (state == ST_RUN) && mism_any && !fail && !s1_mode;
    assign cover_set = counted && !mism_any && s1_mode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RST_STATE;
        end else if (clr) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WARMUP: if (s1_valid && (wcnt_inc == WC_W'(WARMUP))) state_nxt = ST_RUN;
            ST_RUN:    if (capture) state_nxt = ST_HALT;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt       <= '0;
            samp_cnt   <= '0;
            mism_cnt   <= '0;
            fail       <= 1'b0;
            cover_hit  <= 1'b0;
            first_ch   <= '0;
            first_diff <= '0;
            first_idx  <= '0;
        end else if (clr) begin
            wcnt       <= '0;
            samp_cnt   <= '0;
            mism_cnt   <= '0;
            fail       <= 1'b0;
            cover_hit  <= 1'b0;
            first_ch   <= '0;
            first_diff <= '0;
            first_idx  <= '0;
        end else begin
            if (s1_valid && (state == ST_WARMUP)) begin
                wcnt <= wcnt_inc;
            end
            if (counted) begin
                samp_cnt <= CNT_W'(sat_inc(64'(samp_cnt), CNT_W));
                if (mism_any) begin
                    mism_cnt <= CNT_W'(sat_inc(64'(mism_cnt), CNT_W));
                end
            end
            if (capture) begin
                fail       <= 1'b1;
                first_ch   <= enc_ch;
                first_diff <= enc_diff;
                first_idx  <= samp_cnt;
            end
            if (cover_set) begin
                cover_hit <= 1'b1;
            end
        end
    end

    assign busy = (state == ST_WARMUP);

endmodule
`default_nettype wire
